shift_reg_serial: RTL and testbench

Multicycle shift unit that consumes the 5-bit shift amount produced by the shift-amount select stage and the 32-bit operand from the register file, and performs SLL/SRL/SRA (optionally ROR) one bit position per clock. It sits on the datapath next to the ALU and is sequenced by the control unit through a start/done handshake. The result is held stable on the output until the next accepted start, for write-back to the register bank.

---
 rtl/shift_reg_serial.sv | 92 +++++++++
 tb/tb_shift_reg_serial.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift_reg_serial.sv
// Multicycle 32-bit shifter: SLL/SRL/SRA one bit per clock under a start/done handshake.
// Define SHIFT_ROR_EN to add rotate-right on shift_op 3'b100; otherwise that code is a NOP.
module shift_reg_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  shift_op,
  input  logic [4:0]  shamt,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  op_q, op_d, op_dec;
  logic [31:0] data_d;

  // Unsupported codes collapse to NOP at acceptance so SHIFT only sees legal ops.
  always_comb begin
    op_dec = OP_NOP;
    case (shift_op)
      OP_SLL, OP_SRL, OP_SRA: op_dec = shift_op;
`ifdef SHIFT_ROR_EN
      OP_ROR:                 op_dec = shift_op;
`endif
      default:                op_dec = OP_NOP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    data_d  = data_out;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          op_d    = op_dec;
          count_d = (op_dec == OP_NOP) ? 5'd0 : shamt;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (count_q != 5'd0) begin
          count_d = count_q - 5'd1;
          case (op_q)
            OP_SLL:  data_d = {data_out[30:0], 1'b0};
            OP_SRL:  data_d = {1'b0, data_out[31:1]};
            OP_SRA:  data_d = {data_out[31], data_out[31:1]};
`ifdef SHIFT_ROR_EN
            OP_ROR:  data_d = {data_out[0], data_out[31:1]};
`endif
            default: data_d = data_out;
          endcase
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      op_q     <= OP_NOP;
      data_out <= 32'h0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      data_out <= data_d;
    end
  end

  assign busy = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_reg_serial.sv
// Bench for shift_reg_serial: vector table + random ops checked through a result scoreboard,
// plus hand-written reset, busy-ignore and abort sequences.
module tb_shift_reg_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  shift_op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  sh;
    logic [31:0] din;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          lat;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[9];

  shift_reg_serial dut (
    .clk(clk), .reset(reset), .start(start), .shift_op(shift_op),
    .shamt(shamt), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic sb_t model(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] d);
    sb_t r;
    r.lat = sh + 1;
    case (op)
      3'b001:  r.exp = d << sh;
      3'b010:  r.exp = d >> sh;
      3'b011:  r.exp = $unsigned($signed(d) >>> sh);
`ifdef SHIFT_ROR_EN
      3'b100:  r.exp = (d >> sh) | (d << (6'd32 - {1'b0, sh}));
`endif
      default: begin r.exp = d; r.lat = 1; end
    endcase
    return r;
  endfunction

  // One full transaction; repulse>0 re-asserts start with fresh data in that busy cycle.
  task automatic run_op(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] din,
                        input logic [31:0] exp, input int lat, input int repulse);
    sb_t e;
    int  seen;
    seen = 0;
    @(negedge clk);
    shift_op = op; shamt = sh; data_in = din; start = 1'b1;
    @(posedge clk);
    sb.push_back('{exp: exp, lat: lat});
    @(negedge clk);
    start = 1'b0; shift_op = 3'($urandom); shamt = 5'($urandom); data_in = $urandom;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == repulse) begin
        start = 1'b1; data_in = $urandom; shift_op = 3'b001; shamt = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin seen = cyc; break; end
    end
    e = sb.pop_front();
    if (seen == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done in 40 cycles expected latency %0d", e.lat);
      start = 1'b0;
    end else begin
      chk("result", data_out, e.exp);
      chk("latency", seen, e.lat);
      chk("busy_in_done", {31'b0, busy}, 32'd1);
      // start during the done cycle must not be accepted
      start = 1'b1; data_in = $urandom; shift_op = 3'b001; shamt = 5'd3;
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse_ends", {31'b0, done}, 32'd0);
      chk("busy_falls", {31'b0, busy}, 32'd0);
      chk("result_hold", data_out, e.exp);
    end
  endtask

  initial begin
    vecs[0] = '{3'b001, 5'd4,  32'h0000_0001, 32'h0000_0010, 5};
    vecs[1] = '{3'b011, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32};
    vecs[2] = '{3'b010, 5'd31, 32'h8000_0000, 32'h0000_0001, 32};
    vecs[3] = '{3'b001, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    vecs[4] = '{3'b111, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
`ifdef SHIFT_ROR_EN
    vecs[5] = '{3'b100, 5'd1,  32'h0000_0001, 32'h8000_0000, 2};
`else
    vecs[5] = '{3'b100, 5'd1,  32'h0000_0001, 32'h0000_0001, 1};
`endif
    vecs[6] = '{3'b000, 5'd5,  32'h1234_5678, 32'h1234_5678, 1};
    vecs[7] = '{3'b011, 5'd3,  32'h7000_0000, 32'h0E00_0000, 4};
    vecs[8] = '{3'b010, 5'd8,  32'hA5A5_F00F, 32'h00A5_A5F0, 9};

    // reset held with random inputs
    reset = 1'b0; start = 1'b0; shift_op = 3'b0; shamt = 5'd0; data_in = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom); shift_op = 3'($urandom); shamt = 5'($urandom); data_in = $urandom;
      chk("rst_data", data_out, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_data", data_out, 32'h0);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].sh, vecs[i].din, vecs[i].exp, vecs[i].lat, 0);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op;
      logic [4:0]  sh;
      logic [31:0] d;
      sb_t m;
      op = 3'($urandom_range(0, 7)); sh = 5'($urandom); d = $urandom;
      m = model(op, sh, d);
      run_op(op, sh, d, m.exp, m.lat, 0);
    end

    // re-pulsed start while busy is ignored
    run_op(3'b001, 5'd10, 32'h0000_0003, 32'h0000_0C00, 11, 3);

    // reset mid-operation aborts with no done
    @(negedge clk);
    shift_op = 3'b001; shamt = 5'd10; data_in = 32'h0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_data", data_out, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, done}, 32'd0);
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("post_abort_done", {31'b0, done}, 32'd0);
      chk("post_abort_busy", {31'b0, busy}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
